map_state_grid: RTL
===================

Name: map_state_grid

Overview:
- Parametrised successor to the fixed 8x8 minesweeper board-state block: configurable grid size, per-cell flag marking, latched mine map, and a game-status FSM (idle/play/won/lost).
- Sits between the debounced button front end and the VGA/7-seg renderers.
- Owns the cursor position, the revealed/flagged bitmaps and the counters.

Parameters:
- ROWS, 8, grid height (>=2).
- COLS, 8, grid width (>=2).
- XW, $clog2(COLS), cursor_x width.
- YW, $clog2(ROWS), cursor_y width.
- CW, $clog2(ROWS*COLS+1), counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_new_map  in  1  synchronous pulse: start new game, latch mine_flat.
- mine_flat  in  ROWS*COLS  mine map; bit index = y*COLS+x; sampled only when load_new_map=1.
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle move pulses (pre-debounced).
- btn_sel  in  1  reveal the cell under the cursor.
- btn_flag  in  1  toggle the flag on the cell under the cursor.
- revealed_flat  out  ROWS*COLS  1 = cell revealed.
- flagged_flat  out  ROWS*COLS  1 = cell flagged.
- cursor_x  out  XW  cursor column.
- cursor_y  out  YW  cursor row.
- num_revealed  out  CW  count of revealed cells.
- num_flagged  out  CW  count of flagged cells.
- game_state  out  2  0=IDLE, 1=PLAY, 2=WON, 3=LOST.

Behaviour:
- Reset (async, rst_n=0):
  - revealed_flat, flagged_flat, cursor, counters and latched mines = 0.
  - game_state = IDLE.
  - Outputs are registered and change asynchronously on assertion of rst_n=0.
- Latency: all outputs update on the clock edge that samples the input pulse (1-cycle registered).
- load_new_map (any state, highest priority):
  - Clears both bitmaps and both counters; cursor = (0,0).
  - Latches mine_flat and registers safe_cells = ROWS*COLS - popcount(mine_flat).
  - game_state <= PLAY.
  - All other button inputs in the same cycle are ignored.
- IDLE: all buttons ignored.
- WON / LOST:
  - Bitmaps and counters are frozen.
  - Movement still updates the cursor.
  - sel and flag are ignored.
- Movement (PLAY/WON/LOST):
  - up decrements y, down increments y; left decrements x, right increments x.
  - up+down together: y unchanged. left+right together: x unchanged.
  - One vertical and one horizontal pulse together: both axes move in the same cycle (diagonal).
  - At an edge: saturate at 0 and at ROWS-1 / COLS-1 (see optional feature).
- Cell index = cursor_y*COLS + cursor_x, evaluated on the pre-move cursor.
  - sel/flag issued in the same cycle as a move act on the old cell.
- btn_sel in PLAY:
  - Cell flagged or already revealed: no-op.
  - Otherwise: set the revealed bit; num_revealed += 1.
  - If the cell is a mine: game_state <= LOST on the same edge.
  - Else if the new num_revealed == safe_cells: game_state <= WON on the same edge.
- btn_flag in PLAY:
  - Revealed cell: no-op.
  - Otherwise: toggle the flag bit; num_flagged += 1 or -= 1.
- btn_sel and btn_flag together: sel takes priority, flag is ignored.
- safe_cells == 0: the game stays in PLAY; WON is unreachable.
- Counters never exceed ROWS*COLS and never underflow.

Optional Feature:
- Macro: MAP_STATE_CURSOR_WRAP_EN.
- Defined: the cursor wraps around per axis (x=0 & left -> COLS-1; x=COLS-1 & right -> 0; same rule for y).
- Undefined: the cursor saturates at the grid edges.
- All other behaviour is identical in both builds.

Test Plan (ROWS=COLS=8):
- Reset, then load_new_map with mine_flat=64'h1 -> game_state=1, cursor (0,0), num_revealed=0, revealed_flat=0.
- With mine_flat=64'h1: press right, then sel -> revealed_flat[1]=1, num_revealed=1, state PLAY. Then left, sel -> revealed_flat[0]=1, state=3 (LOST). Further sel -> no change.
- At (0,0): flag -> flagged_flat[0]=1, num_flagged=1. sel -> no reveal. flag again -> flagged_flat[0]=0, num_flagged=0.
- Boundary at (0,0), pulse up+left:
  - Wrap undefined: stays (0,0).
  - Wrap defined: goes to (7,7).
  - Pulse down+right together from (3,3) -> (4,4).
- mine_flat=64'h8000_0000_0000_0000: reveal all 63 safe cells -> state=2 (WON) on the edge of the 63rd reveal; num_revealed=63. Then load_new_map -> state=1, all cleared.
- Mid-play, assert rst_n=0 asynchronously (between edges) -> all outputs 0 and state IDLE immediately. After release, button pulses are ignored until load_new_map.

Source files
------------

// File: rtl/map_state_grid.sv
// Minesweeper board state: cursor, revealed/flagged bitmaps, counters, game FSM; cursor wraps at edges when MAP_STATE_CURSOR_WRAP_EN is defined.
// All outputs registered, updated on the edge that samples the pulse; no backpressure, every pulse is consumed in its cycle.
module map_state_grid #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS),
    parameter int CW   = $clog2(ROWS*COLS+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_new_map,
    input  logic [ROWS*COLS-1:0] mine_flat,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_sel,
    input  logic                 btn_flag,
    output logic [ROWS*COLS-1:0] revealed_flat,
    output logic [ROWS*COLS-1:0] flagged_flat,
    output logic [XW-1:0]        cursor_x,
    output logic [YW-1:0]        cursor_y,
    output logic [CW-1:0]        num_revealed,
    output logic [CW-1:0]        num_flagged,
    output logic [1:0]           game_state
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

`ifdef MAP_STATE_CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_mines;
    logic [N-1:0]    r_revealed;
    logic [N-1:0]    r_flagged;
    logic [XW-1:0]   r_cx;
    logic [YW-1:0]   r_cy;
    logic [CW-1:0]   r_num_rev;
    logic [CW-1:0]   r_num_flg;
    logic [CW-1:0]   r_safe;

    logic [IW-1:0]   w_idx;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic [CW-1:0]   w_mine_cnt;
    logic [CW-1:0]   w_safe_new;
    logic [CW-1:0]   w_num_rev_inc;
    logic            w_move_en;
    logic            w_do_sel;
    logic            w_do_flag;
    logic            w_cell_mine;

    // Cell under the cursor before any move in this cycle.
    assign w_idx         = IW'(int'(r_cy) * COLS + int'(r_cx));
    assign w_cell_mine   = r_mines[w_idx];
    assign w_num_rev_inc = r_num_rev + CW'(1);
    assign w_move_en     = (r_state != ST_IDLE);

    assign w_do_sel  = (r_state == ST_PLAY) && btn_sel &&
                       !r_flagged[w_idx] && !r_revealed[w_idx];
    assign w_do_flag = (r_state == ST_PLAY) && btn_flag && !btn_sel &&
                       !r_revealed[w_idx];

    always_comb begin
        w_mine_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_mine_cnt = w_mine_cnt + CW'(mine_flat[i]);
        end
        w_safe_new = CW'(N) - w_mine_cnt;
    end

    // Opposing pulses on one axis cancel; the two axes move independently.
    always_comb begin
        w_x_nxt = r_cx;
        w_y_nxt = r_cy;
        if (btn_left && !btn_right) begin
            if (r_cx == '0) w_x_nxt = WRAP_EN ? X_MAX : '0;
            else            w_x_nxt = r_cx - XW'(1);
        end else if (btn_right && !btn_left) begin
            if (r_cx == X_MAX) w_x_nxt = WRAP_EN ? '0 : X_MAX;
            else               w_x_nxt = r_cx + XW'(1);
        end
        if (btn_up && !btn_down) begin
            if (r_cy == '0) w_y_nxt = WRAP_EN ? Y_MAX : '0;
            else            w_y_nxt = r_cy - YW'(1);
        end else if (btn_down && !btn_up) begin
            if (r_cy == Y_MAX) w_y_nxt = WRAP_EN ? '0 : Y_MAX;
            else               w_y_nxt = r_cy + YW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (load_new_map) begin
            w_state_nxt = ST_PLAY;
        end else if (w_do_sel) begin
            if (w_cell_mine)                     w_state_nxt = ST_LOST;
            else if (w_num_rev_inc == r_safe)    w_state_nxt = ST_WON;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mines    <= '0;
            r_revealed <= '0;
            r_flagged  <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_num_rev  <= '0;
            r_num_flg  <= '0;
            r_safe     <= '0;
        end else if (load_new_map) begin
            r_mines    <= mine_flat;
            r_revealed <= '0;
            r_flagged  <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_num_rev  <= '0;
            r_num_flg  <= '0;
            r_safe     <= w_safe_new;
        end else begin
            if (w_move_en) begin
                r_cx <= w_x_nxt;
                r_cy <= w_y_nxt;
            end
            if (w_do_sel) begin
                r_revealed[w_idx] <= 1'b1;
                r_num_rev         <= w_num_rev_inc;
            end
            if (w_do_flag) begin
                r_flagged[w_idx] <= ~r_flagged[w_idx];
                r_num_flg        <= r_flagged[w_idx] ? r_num_flg - CW'(1)
                                                     : r_num_flg + CW'(1);
            end
        end
    end

    assign revealed_flat = r_revealed;
    assign flagged_flat  = r_flagged;
    assign cursor_x      = r_cx;
    assign cursor_y      = r_cy;
    assign num_revealed  = r_num_rev;
    assign num_flagged   = r_num_flg;
    assign game_state    = r_state;

endmodule
